// File: rtl/gelato_warp_issue_pkg.sv
// Shared types and sizing for the gelato warp issue stage.
// WARP_NUM / SCOREBOARD_SIZE macros override the warp count and dirty slots per warp.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

`ifndef SCOREBOARD_SIZE
`define SCOREBOARD_SIZE 4
`endif

package gelato_warp_issue_pkg;

  localparam int WARP_NUM = `WARP_NUM;
  localparam int SB_SIZE  = `SCOREBOARD_SIZE;

  localparam int REG_W        = 5;
  localparam int INST_W       = 32;
  localparam int WARP_W       = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;
  localparam int ISSUE_PERF_W = 32;
  // Dirty count per warp can reach SB_SIZE slots plus one pending record.
  localparam int SB_CNT_W     = $clog2(SB_SIZE + 2);

  typedef logic [REG_W-1:0]  reg_num_t;
  typedef logic [WARP_W-1:0] warp_num_t;

  typedef struct packed {
    warp_num_t         warp;
    reg_num_t          rd;
    logic [INST_W-1:0] inst;
  } issue_inst_t;

  // x0 is never dirty, so a zero operand can never collide.
  function automatic logic reg_hit(reg_num_t r, reg_num_t dirty);
    return (r != '0) && (r == dirty);
  endfunction

endpackage

// File: rtl/gelato_warp_issue_if.sv
// Downstream issue handshake of the warp issue stage.
interface gelato_warp_issue_if;
  import gelato_warp_issue_pkg::*;

  logic              iss_valid;
  logic              iss_ready;
  warp_num_t         iss_warp;
  reg_num_t          iss_rd;
  logic [INST_W-1:0] iss_inst;

  modport master (output iss_valid, iss_warp, iss_rd, iss_inst, input iss_ready);
  modport slave  (input iss_valid, iss_warp, iss_rd, iss_inst, output iss_ready);
endinterface

// File: rtl/gelato_rr_arbiter.sv
// Round-robin pick: first requester at or after i_ptr, wrapping.
module gelato_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    j             = 0;
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N;
      if (i_req[j]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/gelato_warp_issue.sv
// Per-warp issue stage: one buffered instruction per warp, RAW/WAW and
// scoreboard-capacity checks, round-robin issue, rd record to the scoreboard.
// Optional GELATO_ISSUE_PERF_EN adds saturating issue/stall counters as ports.
module gelato_warp_issue
  import gelato_warp_issue_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_rdy,
  input  logic [WARP_NUM-1:0]               i_in_valid,
  output logic [WARP_NUM-1:0]               o_in_ready,
  input  logic [WARP_NUM*REG_W-1:0]         i_in_rs1,
  input  logic [WARP_NUM*REG_W-1:0]         i_in_rs2,
  input  logic [WARP_NUM*REG_W-1:0]         i_in_rd,
  input  logic [WARP_NUM*INST_W-1:0]        i_in_inst,
  input  logic [WARP_NUM*SB_SIZE*REG_W-1:0] i_sb_regs,
  output reg_num_t                          o_sb_new_reg,
  output warp_num_t                         o_sb_warp_num,
`ifdef GELATO_ISSUE_PERF_EN
  output logic [ISSUE_PERF_W-1:0]           o_perf_issued,
  output logic [ISSUE_PERF_W-1:0]           o_perf_hazard_stall,
  output logic [ISSUE_PERF_W-1:0]           o_perf_full_stall,
`endif
  gelato_warp_issue_if.master               iss
);

  logic [WARP_NUM-1:0] r_buf_valid;
  reg_num_t            r_buf_rs1  [WARP_NUM];
  reg_num_t            r_buf_rs2  [WARP_NUM];
  reg_num_t            r_buf_rd   [WARP_NUM];
  logic [INST_W-1:0]   r_buf_inst [WARP_NUM];

  logic        r_iss_valid;
  issue_inst_t r_iss;
  reg_num_t    r_sb_new_reg;
  warp_num_t   r_sb_warp_num;
  logic        r_pend_valid;
  reg_num_t    r_pend_reg;
  warp_num_t   r_pend_warp;
  warp_num_t   r_rr_ptr;

  logic [WARP_NUM-1:0] w_hazard;
  logic [WARP_NUM-1:0] w_full;
  logic [WARP_NUM-1:0] w_eligible;
  logic [WARP_NUM-1:0] w_in_ready;
  logic [WARP_NUM-1:0] w_capture;
  logic                w_grant_valid;
  warp_num_t           w_grant;
  logic                w_issue_now;
  warp_num_t           w_rr_next;

  // The pending record stands in for the scoreboard entry during the cycle
  // before sb_regs reflects it, both for hazards and for capacity.
  for (genvar gw = 0; gw < WARP_NUM; gw++) begin : g_hz
    logic                w_hit;
    logic [SB_CNT_W-1:0] w_cnt;
    reg_num_t            w_slot;

    // Compare this warp's buffered operands against its dirty slots and pend.
    always_comb begin
      w_hit  = 1'b0;
      w_cnt  = '0;
      w_slot = '0;
      for (int s = 0; s < SB_SIZE; s++) begin
        w_slot = i_sb_regs[(gw*SB_SIZE + s)*REG_W +: REG_W];
        if (w_slot != '0) w_cnt = w_cnt + SB_CNT_W'(1);
        if (reg_hit(r_buf_rs1[gw], w_slot) | reg_hit(r_buf_rs2[gw], w_slot) |
            reg_hit(r_buf_rd[gw], w_slot))
          w_hit = 1'b1;
      end
      if (r_pend_valid && (r_pend_warp == warp_num_t'(gw))) begin
        w_cnt = w_cnt + SB_CNT_W'(1);
        if (reg_hit(r_buf_rs1[gw], r_pend_reg) | reg_hit(r_buf_rs2[gw], r_pend_reg) |
            reg_hit(r_buf_rd[gw], r_pend_reg))
          w_hit = 1'b1;
      end
    end

    assign w_hazard[gw] = w_hit;
    assign w_full[gw]   = (r_buf_rd[gw] != '0) && (w_cnt >= SB_CNT_W'(SB_SIZE));
  end

  assign w_eligible = r_buf_valid & ~w_hazard & ~w_full;

  gelato_rr_arbiter #(.N(WARP_NUM), .IDX_W(WARP_W)) u_arb (
    .i_req         (w_eligible),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant)
  );

  assign w_issue_now = i_rdy & w_grant_valid & (~r_iss_valid | iss.iss_ready);
  assign w_rr_next   = (w_grant == warp_num_t'(WARP_NUM - 1)) ? '0 : w_grant + warp_num_t'(1);

  // A buffer accepts when empty or when its content leaves this cycle.
  always_comb begin
    w_in_ready = '0;
    for (int w = 0; w < WARP_NUM; w++)
      w_in_ready[w] = rst_n & i_rdy &
                      (~r_buf_valid[w] | (w_issue_now & (w_grant == warp_num_t'(w))));
  end

  assign o_in_ready = w_in_ready;
  assign w_capture  = i_in_valid & w_in_ready;

  // Per-warp instruction buffers; a refill wins over the issue clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= '0;
      for (int w = 0; w < WARP_NUM; w++) begin
        r_buf_rs1[w]  <= '0;
        r_buf_rs2[w]  <= '0;
        r_buf_rd[w]   <= '0;
        r_buf_inst[w] <= '0;
      end
    end else if (i_rdy) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        if (w_capture[w]) begin
          r_buf_valid[w] <= 1'b1;
          r_buf_rs1[w]   <= i_in_rs1[w*REG_W +: REG_W];
          r_buf_rs2[w]   <= i_in_rs2[w*REG_W +: REG_W];
          r_buf_rd[w]    <= i_in_rd[w*REG_W +: REG_W];
          r_buf_inst[w]  <= i_in_inst[w*INST_W +: INST_W];
        end else if (w_issue_now && (w_grant == warp_num_t'(w))) begin
          r_buf_valid[w] <= 1'b0;
        end
      end
    end
  end

  // Output register, scoreboard record pulse, pending record and RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid   <= 1'b0;
      r_iss         <= '0;
      r_sb_new_reg  <= '0;
      r_sb_warp_num <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_reg    <= '0;
      r_pend_warp   <= '0;
      r_rr_ptr      <= '0;
    end else if (!i_rdy) begin
      r_sb_new_reg <= '0;
    end else if (w_issue_now) begin
      r_iss_valid   <= 1'b1;
      r_iss.warp    <= w_grant;
      r_iss.rd      <= r_buf_rd[w_grant];
      r_iss.inst    <= r_buf_inst[w_grant];
      r_sb_new_reg  <= r_buf_rd[w_grant];
      r_sb_warp_num <= w_grant;
      r_pend_valid  <= (r_buf_rd[w_grant] != '0);
      r_pend_reg    <= r_buf_rd[w_grant];
      r_pend_warp   <= w_grant;
      r_rr_ptr      <= w_rr_next;
    end else begin
      if (iss.iss_ready) r_iss_valid <= 1'b0;
      r_sb_new_reg <= '0;
      r_pend_valid <= 1'b0;
    end
  end

  assign iss.iss_valid  = r_iss_valid;
  assign iss.iss_warp   = r_iss.warp;
  assign iss.iss_rd     = r_iss.rd;
  assign iss.iss_inst   = r_iss.inst;
  assign o_sb_new_reg   = r_sb_new_reg;
  assign o_sb_warp_num  = r_sb_warp_num;

`ifdef GELATO_ISSUE_PERF_EN
  logic [ISSUE_PERF_W-1:0] r_perf_issued;
  logic [ISSUE_PERF_W-1:0] r_perf_hazard_stall;
  logic [ISSUE_PERF_W-1:0] r_perf_full_stall;
  logic                    w_stall_cycle;

  assign w_stall_cycle = i_rdy & ~w_issue_now;

  // Saturating counters; stalls count only in cycles where nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issued       <= '0;
      r_perf_hazard_stall <= '0;
      r_perf_full_stall   <= '0;
    end else begin
      if (w_issue_now && (r_perf_issued != '1))
        r_perf_issued <= r_perf_issued + ISSUE_PERF_W'(1);
      if (w_stall_cycle && |(r_buf_valid & w_hazard) && (r_perf_hazard_stall != '1))
        r_perf_hazard_stall <= r_perf_hazard_stall + ISSUE_PERF_W'(1);
      if (w_stall_cycle && |(r_buf_valid & w_full) && (r_perf_full_stall != '1))
        r_perf_full_stall <= r_perf_full_stall + ISSUE_PERF_W'(1);
    end
  end

  assign o_perf_issued       = r_perf_issued;
  assign o_perf_hazard_stall = r_perf_hazard_stall;
  assign o_perf_full_stall   = r_perf_full_stall;
`endif

endmodule

// File: tb/tb_gelato_warp_issue.sv
// Bench for gelato_warp_issue: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a behavioural model.
module tb_gelato_warp_issue;
  import gelato_warp_issue_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b1;
  logic                              rdy;
  logic [WARP_NUM-1:0]               in_valid;
  logic [WARP_NUM-1:0]               in_ready;
  logic [WARP_NUM*REG_W-1:0]         in_rs1, in_rs2, in_rd;
  logic [WARP_NUM*INST_W-1:0]        in_inst;
  logic [WARP_NUM*SB_SIZE*REG_W-1:0] sb_regs;
  reg_num_t                          sb_new_reg;
  warp_num_t                         sb_warp_num;
`ifdef GELATO_ISSUE_PERF_EN
  logic [ISSUE_PERF_W-1:0] perf_issued, perf_hazard_stall, perf_full_stall;
`endif

  gelato_warp_issue_if iss_if ();

  gelato_warp_issue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rdy         (rdy),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_rs1      (in_rs1),
    .i_in_rs2      (in_rs2),
    .i_in_rd       (in_rd),
    .i_in_inst     (in_inst),
    .i_sb_regs     (sb_regs),
    .o_sb_new_reg  (sb_new_reg),
    .o_sb_warp_num (sb_warp_num),
`ifdef GELATO_ISSUE_PERF_EN
    .o_perf_issued       (perf_issued),
    .o_perf_hazard_stall (perf_hazard_stall),
    .o_perf_full_stall   (perf_full_stall),
`endif
    .iss           (iss_if)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input int w, input reg_num_t a, input reg_num_t b, input reg_num_t d,
                     input logic [INST_W-1:0] ins);
    in_valid[w] = 1'b1;
    in_rs1[w*REG_W +: REG_W] = a;
    in_rs2[w*REG_W +: REG_W] = b;
    in_rd[w*REG_W +: REG_W]  = d;
    in_inst[w*INST_W +: INST_W] = ins;
  endtask

  task automatic set_slot(input int w, input int s, input reg_num_t v);
    sb_regs[(w*SB_SIZE + s)*REG_W +: REG_W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy = 1'b1;
    in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_inst = '0;
    sb_regs = '0;
    iss_if.iss_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  bit                m_bv [WARP_NUM];
  reg_num_t          m_rs1 [WARP_NUM], m_rs2 [WARP_NUM], m_rd [WARP_NUM];
  logic [INST_W-1:0] m_inst [WARP_NUM];
  bit                m_pv;
  reg_num_t          m_pr;
  int                m_pw, m_rr;
  bit                m_iv;
  int                m_iw;
  reg_num_t          m_ir;
  logic [INST_W-1:0] m_ii;
  reg_num_t          m_sbn;
  int                m_sbw;

  task automatic m_init();
    for (int w = 0; w < WARP_NUM; w++) begin
      m_bv[w] = 0; m_rs1[w] = '0; m_rs2[w] = '0; m_rd[w] = '0; m_inst[w] = '0;
    end
    m_pv = 0; m_pr = '0; m_pw = 0; m_rr = 0;
    m_iv = 0; m_iw = 0; m_ir = '0; m_ii = '0; m_sbn = '0; m_sbw = 0;
  endtask

  // A warp may go when none of its registers is in its dirty list
  // (scoreboard slots plus the record still in flight) and recording rd fits.
  function automatic bit m_ready_to_go(int w);
    reg_num_t dirty[$];
    reg_num_t v;
    if (!m_bv[w]) return 0;
    for (int s = 0; s < SB_SIZE; s++) begin
      v = sb_regs[(w*SB_SIZE + s)*REG_W +: REG_W];
      if (v != 0) dirty.push_back(v);
    end
    if (m_pv && m_pw == w) dirty.push_back(m_pr);
    foreach (dirty[i]) begin
      if (m_rs1[w] == dirty[i] || m_rs2[w] == dirty[i] || m_rd[w] == dirty[i]) return 0;
    end
    if (m_rd[w] != 0 && dirty.size() >= SB_SIZE) return 0;
    return 1;
  endfunction

  task automatic m_step(output logic [WARP_NUM-1:0] exp_in_ready);
    bit found, issue;
    int g;
    found = 0; g = 0;
    exp_in_ready = '0;
    if (!rdy) begin
      m_sbn = '0;
      return;
    end
    for (int k = 0; k < WARP_NUM; k++) begin
      int w;
      w = (m_rr + k) % WARP_NUM;
      if (!found && m_ready_to_go(w)) begin found = 1; g = w; end
    end
    issue = found && (!m_iv || iss_if.iss_ready);
    for (int w = 0; w < WARP_NUM; w++) exp_in_ready[w] = !m_bv[w] || (issue && g == w);
    if (issue) begin
      m_bv[g] = 0;
      m_iv = 1; m_iw = g; m_ir = m_rd[g]; m_ii = m_inst[g];
      m_sbn = m_rd[g]; m_sbw = g;
      m_pv = (m_rd[g] != 0); m_pr = m_rd[g]; m_pw = g;
      m_rr = (g + 1) % WARP_NUM;
    end else begin
      if (iss_if.iss_ready) m_iv = 0;
      m_sbn = '0;
      m_pv = 0;
    end
    for (int w = 0; w < WARP_NUM; w++) begin
      if (in_valid[w] && exp_in_ready[w]) begin
        m_bv[w] = 1;
        m_rs1[w] = in_rs1[w*REG_W +: REG_W];
        m_rs2[w] = in_rs2[w*REG_W +: REG_W];
        m_rd[w]  = in_rd[w*REG_W +: REG_W];
        m_inst[w] = in_inst[w*INST_W +: INST_W];
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int       warp;
    reg_num_t rs1, rs2, rd;
    int       sbw;
    reg_num_t slot;
    bit       exp_iss;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [WARP_NUM-1:0] exp_rdy;

    vecs[0] = '{0, 5'd3, 5'd4, 5'd5, 0, 5'd0, 1'b1};
    vecs[1] = '{1, 5'd7, 5'd1, 5'd8, 1, 5'd7, 1'b0};
    vecs[2] = '{1, 5'd2, 5'd7, 5'd8, 1, 5'd7, 1'b0};
    vecs[3] = '{2, 5'd1, 5'd2, 5'd7, 2, 5'd7, 1'b0};
    vecs[4] = '{0, 5'd7, 5'd7, 5'd7, 1, 5'd7, 1'b1};
    vecs[5] = '{3, 5'd0, 5'd0, 5'd0, 3, 5'd9, 1'b1};
    vecs[6] = '{1, 5'd9, 5'd3, 5'd4, 1, 5'd8, 1'b1};

    rdy = 1'b1;
    in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_inst = '0;
    sb_regs = '0;
    iss_if.iss_ready = 1'b1;

    // reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, '0);
    chk("rst_iss_valid", iss_if.iss_valid, 0);
    chk("rst_sb_new_reg", sb_new_reg, 0);
    chk("rst_sb_warp_num", sb_warp_num, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, {WARP_NUM{1'b1}});
    @(negedge clk);

    // single-instruction vectors
    for (int i = 0; i < 7; i++) begin
      sb_regs = '0;
      set_slot(vecs[i].sbw, 0, vecs[i].slot);
      put(vecs[i].warp, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 32'hA000_0000 + i);
      tick();
      in_valid = '0;
      tick();
      chk($sformatf("vec%0d_iss_valid", i), iss_if.iss_valid, vecs[i].exp_iss);
      if (!vecs[i].exp_iss) begin
        chk($sformatf("vec%0d_no_record", i), sb_new_reg, 0);
        sb_regs = '0;
        tick();
        chk($sformatf("vec%0d_late_valid", i), iss_if.iss_valid, 1);
      end
      chk($sformatf("vec%0d_iss_warp", i), iss_if.iss_warp, vecs[i].warp);
      chk($sformatf("vec%0d_iss_rd", i), iss_if.iss_rd, vecs[i].rd);
      chk($sformatf("vec%0d_iss_inst", i), iss_if.iss_inst, 32'hA000_0000 + i);
      chk($sformatf("vec%0d_sb_new_reg", i), sb_new_reg, vecs[i].rd);
      chk($sformatf("vec%0d_sb_warp_num", i), sb_warp_num, vecs[i].warp);
      tick();
      chk($sformatf("vec%0d_pulse_end", i), sb_new_reg, 0);
      chk($sformatf("vec%0d_valid_drop", i), iss_if.iss_valid, 0);
    end

    // RAW on just-issued rd: blocked by pend, then by scoreboard
    do_reset();
    put(2, 5'd1, 5'd2, 5'd9, 32'hB0);
    tick();
    put(2, 5'd0, 5'd9, 5'd10, 32'hB1);
    tick();
    chk("pend_first_rd", iss_if.iss_rd, 9);
    chk("pend_first_rec", sb_new_reg, 9);
    chk("pend_first_warp", sb_warp_num, 2);
    in_valid = '0;
    tick();
    chk("pend_block", iss_if.iss_valid, 0);
    set_slot(2, 0, 5'd9);
    tick();
    chk("sb_block", iss_if.iss_valid, 0);
    sb_regs = '0;
    tick();
    chk("raw_release_valid", iss_if.iss_valid, 1);
    chk("raw_release_rd", iss_if.iss_rd, 10);
`ifdef GELATO_ISSUE_PERF_EN
    chk("perf_hazard_stall", perf_hazard_stall, 2);
    chk("perf_issued", perf_issued, 2);
`endif
    tick();

    // round-robin over all warps with continuous refill
    do_reset();
    for (int w = 0; w < WARP_NUM; w++) put(w, 5'd0, 5'd0, reg_num_t'(16 + w), 32'hC0 + w);
    tick();
    for (int k = 0; k < WARP_NUM + 1; k++) begin
      tick();
      chk($sformatf("rr_valid%0d", k), iss_if.iss_valid, 1);
      chk($sformatf("rr_grant%0d", k), iss_if.iss_warp, k % WARP_NUM);
    end
    in_valid = '0;
    repeat (4) tick();

    // scoreboard capacity: three slots plus pend fills, four slots full
    do_reset();
    set_slot(3, 0, 5'd11); set_slot(3, 1, 5'd12); set_slot(3, 2, 5'd13);
    put(3, 5'd1, 5'd3, 5'd2, 32'hD0);
    tick();
    put(3, 5'd0, 5'd0, 5'd4, 32'hD1);
    tick();
    chk("cap3_issue_rd", iss_if.iss_rd, 2);
    in_valid = '0;
    tick();
    chk("cap_pend_full", iss_if.iss_valid, 0);
    tick();
    chk("cap_after_pend_valid", iss_if.iss_valid, 1);
    chk("cap_after_pend_rd", iss_if.iss_rd, 4);
    set_slot(3, 3, 5'd14);
    put(3, 5'd1, 5'd3, 5'd2, 32'hD2);
    tick();
    in_valid = '0;
    tick();
    chk("full_stall", iss_if.iss_valid, 0);
    do_reset();
    set_slot(3, 0, 5'd11); set_slot(3, 1, 5'd12); set_slot(3, 2, 5'd13); set_slot(3, 3, 5'd14);
    put(3, 5'd1, 5'd3, 5'd0, 32'hD3);
    tick();
    in_valid = '0;
    tick();
    chk("full_rd0_valid", iss_if.iss_valid, 1);
    chk("full_rd0_warp", iss_if.iss_warp, 3);
    chk("full_rd0_no_record", sb_new_reg, 0);
    sb_regs = '0;
    tick();

    // downstream backpressure then async reset mid-stall
    do_reset();
    iss_if.iss_ready = 1'b0;
    put(1, 5'd1, 5'd2, 5'd6, 32'hE0);
    tick();
    in_valid = '0;
    put(2, 5'd0, 5'd0, 5'd7, 32'hE1);
    tick();
    in_valid = '0;
    chk("bp_first_rd", iss_if.iss_rd, 6);
    chk("bp_first_rec", sb_new_reg, 6);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_valid%0d", k), iss_if.iss_valid, 1);
      chk($sformatf("bp_warp%0d", k), iss_if.iss_warp, 1);
      chk($sformatf("bp_rd%0d", k), iss_if.iss_rd, 6);
      chk($sformatf("bp_inst%0d", k), iss_if.iss_inst, 32'hE0);
      chk($sformatf("bp_no_pulse%0d", k), sb_new_reg, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_iss_valid", iss_if.iss_valid, 0);
    chk("mid_rst_sb_warp_num", sb_warp_num, 0);
    chk("mid_rst_sb_new_reg", sb_new_reg, 0);
    chk("mid_rst_in_ready", in_ready, '0);
    @(negedge clk);
    rst_n = 1'b1;
    iss_if.iss_ready = 1'b1;
    tick();
    tick();
    chk("mid_rst_dropped", iss_if.iss_valid, 0);

    // randomized traffic against the reference model
    do_reset();
    m_init();
    for (int c = 0; c < 600; c++) begin
      chk("rnd_iss_valid", iss_if.iss_valid, m_iv);
      if (m_iv) begin
        chk("rnd_iss_warp", iss_if.iss_warp, m_iw);
        chk("rnd_iss_rd", iss_if.iss_rd, m_ir);
        chk("rnd_iss_inst", iss_if.iss_inst, m_ii);
      end
      chk("rnd_sb_new_reg", sb_new_reg, m_sbn);
      chk("rnd_sb_warp_num", sb_warp_num, m_sbw);
      rdy = ($urandom_range(0, 9) != 0);
      iss_if.iss_ready = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < WARP_NUM; w++) begin
        in_valid[w] = $urandom_range(0, 1) == 1;
        in_rs1[w*REG_W +: REG_W] = reg_num_t'($urandom_range(0, 7));
        in_rs2[w*REG_W +: REG_W] = reg_num_t'($urandom_range(0, 7));
        in_rd[w*REG_W +: REG_W]  = reg_num_t'($urandom_range(0, 7));
        in_inst[w*INST_W +: INST_W] = $urandom;
        for (int s = 0; s < SB_SIZE; s++)
          set_slot(w, s, ($urandom_range(0, 3) == 0) ? reg_num_t'($urandom_range(1, 7)) : '0);
      end
      #1;
      m_step(exp_rdy);
      chk("rnd_in_ready", in_ready, exp_rdy);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
